// File: rtl/command_receiver.sv
// Purpose    : receive-side front end; decodes UART bytes into vector loads (BRAM_A/BRAM_B) and op commands.
// Latency    : rx_ready -> BRAM write 1 cycle; rx_ready (op code) -> result pulse 2 cycles.
// Backpressure: none toward uart_rx; new commands are blocked (bytes discarded) until done pulses.
//
// Ports:
//   clk, reset             system clock, synchronous active-high reset
//   rx_ready, rx_data      1-cycle strobe + received byte from uart_rx
//   done                   1-cycle pulse from the processing block: command finished
//   bram_addr, bram_wdata  shared BRAM write address/data
//   bramA_we, bramB_we     per-BRAM write enables (never both high)
//   result                 [3]=cmd pulse, [2]=1 vector/0 scalar, [1:0]=op code
//   load_done              pulses with the write of the last payload byte
//   cmd_error              pulses one cycle after an unknown command byte
//   timeout                pulses when a load is abandoned on an idle gap
//   busy                   high in every state except IDLE
//
// Optional feature: define RX_TIMEOUT_EN to build the load gap timer (TIMEOUT_CYCLES);
// without it timeout is tied low and LOAD waits indefinitely.
module command_receiver #(
    parameter int NBytes         = 1024,
    parameter int TIMEOUT_CYCLES = 1000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       rx_ready,
    input  logic [7:0] rx_data,
    input  logic       done,
    output logic [9:0] bram_addr,
    output logic [7:0] bram_wdata,
    output logic       bramA_we,
    output logic       bramB_we,
    output logic [3:0] result,
    output logic       load_done,
    output logic       cmd_error,
    output logic       timeout,
    output logic       busy
);

    generate
        if (NBytes < 2 || NBytes > 1024 || TIMEOUT_CYCLES < 2) begin : g_bad_param
            $error("command_receiver: NBytes must be 2..1024 and TIMEOUT_CYCLES >= 2");
        end
    endgenerate

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        ISSUE,
        WAIT_DONE
    } state_t;

    localparam logic [9:0] LastAddr = 10'(NBytes - 1);

    state_t     state_q;
    logic       tgt_b_q;      // 0: load targets BRAM_A, 1: BRAM_B
    logic [2:0] cmd_q;        // latched {vector, op}
    logic [9:0] addr_q;       // next payload address
    logic [9:0] addr_d;
    logic       last_byte;

    logic [9:0] bram_addr_q;
    logic [7:0] bram_wdata_q;
    logic       bramA_we_q;
    logic       bramB_we_q;
    logic [3:0] result_q;
    logic       load_done_q;
    logic       cmd_error_q;
    logic       timeout_q;
    logic       busy_q;

    // Command codes 0x03..0x08 map to op = low two bits + 1:
    // 03->0, 04->1, 05->2, 06->3, 07->0, 08->1.
    logic [1:0] op_code;
    assign op_code = rx_data[1:0] + 2'd1;

    assign last_byte = (addr_q == LastAddr);
    assign addr_d    = last_byte ? 10'd0 : addr_q + 10'd1;

`ifdef RX_TIMEOUT_EN
    localparam int GapW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [GapW-1:0] GapLimit = GapW'(TIMEOUT_CYCLES - 1);
    // Cycles elapsed since the last accepted byte (1 in the cycle after it),
    // so the pulse lands exactly TIMEOUT_CYCLES cycles after that byte.
    logic [GapW-1:0] gap_q;
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            tgt_b_q      <= 1'b0;
            cmd_q        <= 3'd0;
            addr_q       <= 10'd0;
            bram_addr_q  <= 10'd0;
            bram_wdata_q <= 8'd0;
            bramA_we_q   <= 1'b0;
            bramB_we_q   <= 1'b0;
            result_q     <= 4'd0;
            load_done_q  <= 1'b0;
            cmd_error_q  <= 1'b0;
            timeout_q    <= 1'b0;
            busy_q       <= 1'b0;
`ifdef RX_TIMEOUT_EN
            gap_q        <= '0;
`endif
        end else begin
            // Pulse outputs default low every cycle.
            bramA_we_q  <= 1'b0;
            bramB_we_q  <= 1'b0;
            result_q    <= 4'd0;
            load_done_q <= 1'b0;
            cmd_error_q <= 1'b0;
            timeout_q   <= 1'b0;

            case (state_q)
                IDLE: begin
                    if (rx_ready) begin
                        case (rx_data)
                            8'h01, 8'h02: begin
                                tgt_b_q <= rx_data[1];
                                addr_q  <= 10'd0;
                                state_q <= LOAD;
                                busy_q  <= 1'b1;
`ifdef RX_TIMEOUT_EN
                                gap_q   <= GapW'(1);
`endif
                            end
                            8'h03, 8'h04, 8'h05, 8'h06: begin
                                cmd_q   <= {1'b1, op_code};
                                state_q <= ISSUE;
                                busy_q  <= 1'b1;
                            end
                            8'h07, 8'h08: begin
                                cmd_q   <= {1'b0, op_code};
                                state_q <= ISSUE;
                                busy_q  <= 1'b1;
                            end
                            default: cmd_error_q <= 1'b1;
                        endcase
                    end
                end

                LOAD: begin
                    if (rx_ready) begin
                        bramA_we_q   <= ~tgt_b_q;
                        bramB_we_q   <= tgt_b_q;
                        bram_wdata_q <= rx_data;
                        bram_addr_q  <= addr_q;
                        addr_q       <= addr_d;
`ifdef RX_TIMEOUT_EN
                        gap_q        <= GapW'(1);
`endif
                        if (last_byte) begin
                            load_done_q <= 1'b1;
                            state_q     <= IDLE;
                            busy_q      <= 1'b0;
                        end
                    end
`ifdef RX_TIMEOUT_EN
                    else if (gap_q == GapLimit) begin
                        // Abandon the load; whatever was written stays in BRAM.
                        timeout_q <= 1'b1;
                        addr_q    <= 10'd0;
                        state_q   <= IDLE;
                        busy_q    <= 1'b0;
                    end else begin
                        gap_q <= gap_q + GapW'(1);
                    end
`endif
                end

                ISSUE: begin
                    result_q <= {1'b1, cmd_q};
                    state_q  <= WAIT_DONE;
                end

                WAIT_DONE: begin
                    // Any rx byte here is dropped, including one coincident with done.
                    if (done) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                end

                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign bram_addr  = bram_addr_q;
    assign bram_wdata = bram_wdata_q;
    assign bramA_we   = bramA_we_q;
    assign bramB_we   = bramB_we_q;
    assign result     = result_q;
    assign load_done  = load_done_q;
    assign cmd_error  = cmd_error_q;
`ifdef RX_TIMEOUT_EN
    assign timeout    = timeout_q;
`else
    assign timeout    = 1'b0;
`endif
    assign busy       = busy_q;

endmodule
